// File: rtl/spi_master_tx.sv
// spi_master_tx: mode-0 SPI initiator. Shifts a WIDTH-bit word out on MOSI
// (MSB first) under a generated SCLK and active-low CS, and captures MISO into
// a parallel word. Every SCLK phase lasts CLKDIV clk cycles so that a slow,
// synchronized/debounced responder sees clean edges.
//
// Ports:
//   clk     in   system clock, posedge
//   reset   in   synchronous active-high reset
//   start   in   transaction request, sampled only while idle
//   txdata  in   WIDTH  word to send, latched when start is accepted
//   rxdata  out  WIDTH  received word, updated together with done
//   busy    out  high from the cycle after acceptance until done
//   done    out  one-cycle completion pulse, coincident with cs rising
//   sclk    out  serial clock, idles low
//   mosi    out  serial data out, changes only while sclk is low
//   miso    in   serial data in, sampled on the cycle sclk falls
//   cs      out  chip select, active low, idles high
//
// WIDTH must be at least 2; CLKDIV must be in 2..255.
module spi_master_tx #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned CLKDIV = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] txdata,
  output logic [WIDTH-1:0] rxdata,
  output logic             busy,
  output logic             done,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso,
  output logic             cs
);

  localparam int unsigned CNT_W = $clog2(CLKDIV) + 1;
  localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(CLKDIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_HOLD
  } state_t;

  state_t             state_q,  state_d;
  logic [CNT_W-1:0]   phase_q,  phase_d;
  logic [BIT_W-1:0]   bit_q,    bit_d;
  logic [WIDTH-1:0]   tx_sr_q,  tx_sr_d;
  logic [WIDTH-1:0]   rx_sr_q,  rx_sr_d;
  logic [WIDTH-1:0]   rxdata_q, rxdata_d;
  logic               busy_q,   busy_d;
  logic               done_q,   done_d;
  logic               sclk_q,   sclk_d;
  logic               mosi_q,   mosi_d;
  logic               cs_q,     cs_d;

  logic               phase_end;

  assign phase_end = (phase_q == PHASE_LAST);

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q + CNT_W'(1);
    bit_d    = bit_q;
    tx_sr_d  = tx_sr_q;
    rx_sr_d  = rx_sr_q;
    rxdata_d = rxdata_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    cs_d     = cs_q;

    unique case (state_q)
      S_IDLE: begin
        phase_d = '0;
        if (start) begin
          tx_sr_d = txdata;
          bit_d   = '0;
          cs_d    = 1'b0;
          mosi_d  = txdata[WIDTH-1];
          busy_d  = 1'b1;
          state_d = S_SETUP;
        end
      end

      S_SETUP: begin
        if (phase_end) begin
          sclk_d  = 1'b1;
          state_d = S_HIGH;
        end
      end

      // Sample MISO on the cycle SCLK falls; the responder shifts on that fall.
      S_HIGH: begin
        if (phase_end) begin
          rx_sr_d = {rx_sr_q[WIDTH-2:0], miso};
          sclk_d  = 1'b0;
          if (bit_q == BIT_LAST) begin
            state_d = S_HOLD;
          end else begin
            tx_sr_d = {tx_sr_q[WIDTH-2:0], 1'b0};
            mosi_d  = tx_sr_q[WIDTH-2];
            bit_d   = bit_q + BIT_W'(1);
            state_d = S_LOW;
          end
        end
      end

      S_LOW: begin
        if (phase_end) begin
          sclk_d  = 1'b1;
          state_d = S_HIGH;
        end
      end

      S_HOLD: begin
        if (phase_end) begin
          cs_d     = 1'b1;
          mosi_d   = 1'b0;
          busy_d   = 1'b0;
          rxdata_d = rx_sr_q;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Each phase starts counting from zero.
    if (state_d != state_q) begin
      phase_d = '0;
    end
  end

  // State register. A reset while a transaction is in flight aborts it but
  // keeps the last completed word visible on rxdata; a reset while idle
  // (including power-up) clears rxdata.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      bit_q   <= '0;
      tx_sr_q <= '0;
      rx_sr_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_q    <= 1'b1;
      if (busy_q) begin
        rxdata_q <= rxdata_q;
      end else begin
        rxdata_q <= '0;
      end
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      tx_sr_q  <= tx_sr_d;
      rx_sr_q  <= rx_sr_d;
      rxdata_q <= rxdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      cs_q     <= cs_d;
    end
  end

  assign rxdata = rxdata_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign sclk   = sclk_q;
  assign mosi   = mosi_q;
  assign cs     = cs_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx (WIDTH=8, CLKDIV=4). Stimulus pushes the expected
// (mosi word, rx word) per transaction; a monitor pops on every done pulse.
module tb_spi_master_tx;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned CLKDIV = 4;
  localparam int unsigned CS_LOW = CLKDIV * (2 * WIDTH + 1);  // 68

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] txdata;
  logic [WIDTH-1:0] rxdata;
  logic             busy;
  logic             done;
  logic             sclk;
  logic             mosi;
  logic             miso;
  logic             cs;

  spi_master_tx #(.WIDTH(WIDTH), .CLKDIV(CLKDIV)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .txdata (txdata),
    .rxdata (rxdata),
    .busy   (busy),
    .done   (done),
    .sclk   (sclk),
    .mosi   (mosi),
    .miso   (miso),
    .cs     (cs)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] tx;
    logic [WIDTH-1:0] rx;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Responder: presents its word MSB first from cs fall, shifts on sclk fall.
  logic [WIDTH-1:0] resp_word = '0;
  logic [WIDTH-1:0] resp_lat  = '0;
  int               ridx      = 0;

  initial miso = 1'b0;

  always @(negedge cs) begin
    resp_lat = resp_word;
    ridx     = WIDTH - 1;
    miso     = resp_word[WIDTH-1];
  end

  always @(negedge sclk) begin
    if (cs === 1'b0 && ridx > 0) begin
      ridx--;
      miso = resp_lat[ridx];
    end
  end

  // Monitor: observes the pins and checks each completed transaction.
  logic             sclk_prev = 1'b0;
  logic             cs_prev   = 1'b1;
  logic             done_prev = 1'b0;
  logic [WIDTH-1:0] mosi_word = '0;
  int               pulses    = 0;
  int               cs_low_cnt = 0;
  int               cs_high_cnt = 0;
  int               last_gap  = 0;
  int               done_cnt  = 0;
  int               cs_falls  = 0;
  exp_t             e;

  always @(negedge clk) begin
    if (cs_prev === 1'b1 && cs === 1'b0) begin
      pulses     = 0;
      cs_low_cnt = 0;
      mosi_word  = '0;
      last_gap   = cs_high_cnt;
      cs_falls++;
    end
    if (cs === 1'b0) cs_low_cnt++;
    if (cs === 1'b1) cs_high_cnt++;
    if (cs_prev === 1'b0 && cs === 1'b1) cs_high_cnt = 1;
    if (cs === 1'b0 && sclk === 1'b1 && sclk_prev === 1'b0) begin
      mosi_word = {mosi_word[WIDTH-2:0], mosi};
      pulses++;
    end
    if (done_prev === 1'b1) check("done_width", 32'(done), 32'd0);
    if (done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with empty queue, expected none");
      end else begin
        e = exp_q.pop_front();
        check("mosi_word", 32'(mosi_word), 32'(e.tx));
        check("rxdata", 32'(rxdata), 32'(e.rx));
        check("cs_low_cycles", 32'(cs_low_cnt), 32'(CS_LOW));
        check("sclk_pulses", 32'(pulses), 32'(WIDTH));
        check("cs_at_done", 32'(cs), 32'd1);
        check("busy_at_done", 32'(busy), 32'd0);
      end
    end
    sclk_prev = sclk;
    cs_prev   = cs;
    done_prev = done;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done_cnt(input int target, input string name);
    int budget;
    budget = 2000;
    while (done_cnt < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (done_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout, done count %0d expected %0d", name, done_cnt, target);
    end
  endtask

  task automatic wait_cs_falls(input int target, input string name);
    int budget;
    budget = 2000;
    while (cs_falls < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (cs_falls < target) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout, cs falls %0d expected %0d", name, cs_falls, target);
    end
  endtask

  task automatic issue(input logic [WIDTH-1:0] tx, input logic [WIDTH-1:0] rsp);
    exp_t x;
    x.tx = tx;
    x.rx = rsp;
    exp_q.push_back(x);
    resp_word = rsp;
    txdata    = tx;
    start     = 1'b1;
    cyc(1);
    start     = 1'b0;
  endtask

  initial begin
    int budget;
    reset  = 1'b1;
    start  = 1'b0;
    txdata = '0;

    // Reset and idle values.
    cyc(3);
    reset = 1'b0;
    cyc(2);
    check("rst_cs", 32'(cs), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rxdata", 32'(rxdata), 32'h00);

    // A5 out, 3C back; a second start mid-transfer must be ignored.
    issue(8'hA5, 8'h3C);
    check("busy_after_start", 32'(busy), 32'd1);
    check("cs_after_start", 32'(cs), 32'd0);
    cyc(33);
    txdata = 8'hFF;
    start  = 1'b1;
    cyc(1);
    start  = 1'b0;
    wait_done_cnt(1, "t2_done");
    cyc(100);
    check("t3_single_window", 32'(cs_falls), 32'd1);
    check("t3_done_count", 32'(done_cnt), 32'd1);
    check("t3_rxdata", 32'(rxdata), 32'h3C);

    // Reset during the 4th sclk high phase aborts without done.
    issue(8'h5A, 8'hE7);
    budget = 2000;
    while (!(pulses == 4 && sclk === 1'b1) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("t4_reach_4th_high", 32'(pulses), 32'd4);
    void'(exp_q.pop_back());
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check("t4_cs", 32'(cs), 32'd1);
    check("t4_sclk", 32'(sclk), 32'd0);
    check("t4_done", 32'(done), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_rxdata_kept", 32'(rxdata), 32'h3C);
    cyc(10);
    check("t4_no_done", 32'(done_cnt), 32'd1);
    issue(8'h96, 8'h69);
    wait_done_cnt(2, "t4_restart_done");
    cyc(5);

    // Start held high across two back-to-back transactions.
    begin
      exp_t x;
      x.tx = 8'h00; x.rx = 8'h5A; exp_q.push_back(x);
      x.tx = 8'hFF; x.rx = 8'hC3; exp_q.push_back(x);
    end
    resp_word = 8'h5A;
    txdata    = 8'h00;
    start     = 1'b1;
    wait_cs_falls(4, "t5_first_cs");
    txdata    = 8'hFF;
    resp_word = 8'hC3;
    wait_cs_falls(5, "t5_second_cs");
    start     = 1'b0;
    check("t5_gap_ge1", 32'(last_gap >= 1), 32'd1);
    wait_done_cnt(4, "t5_done");
    cyc(100);
    check("t5_done_count", 32'(done_cnt), 32'd4);
    check("t5_cs_idle", 32'(cs), 32'd1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
